// File: rtl/nand_sweep_checker_if.sv
// Bundle of the NAND checker's control and observation signals.
// The err_vec/err_valid capture pair exists only when NAND_CHK_ERRCAP_EN is defined.
interface nand_sweep_checker_if;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
`ifdef NAND_CHK_ERRCAP_EN
  logic [1:0] err_vec;
  logic       err_valid;

  modport master (output start, y,
                  input  a, b, busy, done, pass, err_cnt, err_vec, err_valid);
  modport slave  (input  start, y,
                  output a, b, busy, done, pass, err_cnt, err_vec, err_valid);
`else
  modport master (output start, y,
                  input  a, b, busy, done, pass, err_cnt);
  modport slave  (input  start, y,
                  output a, b, busy, done, pass, err_cnt);
`endif
endinterface

// File: rtl/nand_sweep_checker.sv
// Exhaustive sweep tester for an external 2-input NAND: drives 00,01,10,11 for
// HOLD cycles each, compares y one cycle later. Optional first-error capture: NAND_CHK_ERRCAP_EN.
module nand_sweep_checker #(
  parameter int unsigned HOLD   = 4,
  parameter int unsigned PASSES = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  nand_sweep_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] vec;
  logic [7:0] hold_cnt;
  logic [7:0] pass_cnt;
  logic [7:0] err_cnt;
  logic       pass_q;

  logic mismatch;
  logic hold_last;
  logic sweep_last;
  logic accept;

  assign accept     = (state == IDLE) && bus.start;
  assign mismatch   = bus.y != ~(vec[1] & vec[0]);
  assign hold_last  = hold_cnt == 8'(HOLD - 1);
  assign sweep_last = (vec == 2'b11) && (pass_cnt == 8'(PASSES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first, so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = DRIVE;
      DRIVE:   if (hold_last) state_nxt = CHECK;
      CHECK:   state_nxt = sweep_last ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector, counters and verdict; everything holds outside the listed states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      vec      <= 2'b00;
      hold_cnt <= 8'd0;
      pass_cnt <= 8'd0;
      err_cnt  <= 8'd0;
      pass_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            vec      <= 2'b00;
            hold_cnt <= 8'd0;
            pass_cnt <= 8'd0;
            err_cnt  <= 8'd0;
            pass_q   <= 1'b0;
          end
        end
        DRIVE: hold_cnt <= hold_cnt + 8'd1;
        CHECK: begin
          hold_cnt <= 8'd0;
          if (mismatch && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
          if (sweep_last) begin
            vec    <= 2'b00;
            // The final compare is folded in here since err_cnt updates on this same edge.
            pass_q <= (err_cnt == 8'd0) && !mismatch;
          end else begin
            vec <= vec + 2'd1;
            if (vec == 2'b11) pass_cnt <= pass_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a       = vec[1];
  assign bus.b       = vec[0];
  assign bus.busy    = state != IDLE;
  assign bus.done    = state == DONE;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_cnt;

`ifdef NAND_CHK_ERRCAP_EN
  logic [1:0] err_vec_q;
  logic       err_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vec_q   <= 2'b00;
      err_valid_q <= 1'b0;
    end else if (accept) begin
      err_vec_q   <= 2'b00;
      err_valid_q <= 1'b0;
    end else if ((state == CHECK) && mismatch && !err_valid_q) begin
      err_vec_q   <= vec;
      err_valid_q <= 1'b1;
    end
  end

  assign bus.err_vec   = err_vec_q;
  assign bus.err_valid = err_valid_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: doc/nand_sweep_checker.md
NAND_SWEEP_CHECKER -- requirements
Module: nand_sweep_checker

Interface
REQ-001 The parameter HOLD SHALL be defined with default 4: the number of cycles each input vector is driven before checking, legal range 1..255.
REQ-002 The parameter PASSES SHALL be defined with default 1: the number of full 4-vector sweeps per run, legal range 1..255.
REQ-003 The design SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk SHALL be: input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 Port rst_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-006 Port start SHALL be: input, 1 bit, request to begin a run; sampled only in IDLE.
REQ-007 Port y SHALL be: input, 1 bit, output of the downstream 2-input NAND under test.
REQ-008 Port a SHALL be: output, 1 bit, first NAND operand, registered.
REQ-009 Port b SHALL be: output, 1 bit, second NAND operand, registered.
REQ-010 Port busy SHALL be: output, 1 bit, high in every state except IDLE.
REQ-011 Port done SHALL be: output, 1 bit, one-cycle pulse marking the end of a run.
REQ-012 Port pass SHALL be: output, 1 bit, run verdict, valid from done and held until the next accepted start.
REQ-013 Port err_cnt SHALL be: output, 8 bits, saturating mismatch count for the current or last run.

Function
REQ-014 The block SHALL implement the states IDLE, DRIVE, CHECK and DONE.
REQ-015 IDLE SHALL go to DRIVE on the edge where start=1; that edge clears err_cnt and pass, sets {a,b}=2'b00 and zeroes the hold counter.
REQ-016 DRIVE SHALL hold {a,b} stable for exactly HOLD cycles, then go to CHECK.
REQ-017 CHECK SHALL last one cycle; at its closing edge y is compared against ~(a&b), and a mismatch increments err_cnt, saturating at 255.
REQ-018 After CHECK, {a,b} SHALL advance in the order 00, 01, 10, 11; 11 wraps to 00 and increments the pass counter.
REQ-019 After CHECK of vector 11 in the final pass, the block SHALL go to DONE instead of wrapping.
REQ-020 DONE SHALL last one cycle with done=1 and pass=(err_cnt==0 including the final compare); it then goes to IDLE.
REQ-021 Run latency SHALL be 4*PASSES*(HOLD+1) cycles from the start edge to entering DONE; with defaults, done is high in cycle 21 after the start edge.
REQ-022 start SHALL be ignored in DRIVE, CHECK and DONE; a start held high through DONE is accepted on the first IDLE cycle.
REQ-023 {a,b} SHALL be 2'b00 in IDLE and DONE.
REQ-024 The err_cnt value, pass and the optional capture outputs SHALL hold their values in IDLE.

Reset
REQ-025 While rst_n=0, the block SHALL immediately enter IDLE with a=0, b=0, busy=0, done=0, pass=0 and err_cnt=0, regardless of the state it was in.
REQ-026 All counters and the vector register SHALL clear under reset.
REQ-027 After rst_n rises, the first start SHALL be accepted normally.

Configuration
REQ-028 With macro NAND_CHK_ERRCAP_EN defined, the block SHALL add output err_vec (2 bits) and output err_valid (1 bit).
REQ-029 With the macro defined, the first mismatch of a run SHALL latch {a,b} into err_vec and set err_valid; later mismatches leave both unchanged, and both clear on an accepted start and on reset.
REQ-030 With the macro undefined, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Scenario: reset mid-run (rst_n=0 during DRIVE of vector 10) -> all outputs 0 in the same cycle; next start runs a full sweep.
REQ-032 Scenario: correct NAND model, HOLD=4, PASSES=1 -> vectors 00/01/10/11 each driven 5 cycles; done in cycle 21; pass=1, err_cnt=0.
REQ-033 Scenario: y stuck at 0 -> err_cnt=3, pass=0; with the macro, err_vec=2'b00 and err_valid=1.
REQ-034 Scenario: y=a&b, PASSES=100 -> 400 mismatches; err_cnt saturates at 255, pass=0.
REQ-035 Scenario: start pulsed during CHECK and held through DONE -> first pulse ignored; second run starts on the IDLE cycle after DONE.
REQ-036 Scenario: HOLD=1, PASSES=2, correct model -> done in cycle 17; a/b toggle every 2 cycles; pass=1.
